// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: LSU state encoding, alignment mask and
// exception codes also consumed by the CP0 block.
package mips_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // CP0 Cause.ExcCode values for data-side faults
  localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES = 5'd5;
  localparam logic [4:0] EXC_CODE_DBE  = 5'd7;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |(addr_lo & WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_dmem_bus_fsm.sv
// Data-memory bus sequencer: req/ack handshake, timeout counter, load-data
// capture and bus-error flag for the MEM stage.
module dmem_bus_fsm
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_mem_op,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_dm_ack,
  input  logic [DATA_W-1:0] i_dm_rdata,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [DATA_W-1:0] o_dm_addr,
  output logic [DATA_W-1:0] o_dm_wdata,
  output logic              o_stall_req,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_buserr
);

  lsu_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dm_req;
  logic              r_dm_we;
  logic [DATA_W-1:0] r_dm_addr;
  logic [DATA_W-1:0] r_dm_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_buserr;
  logic              w_stall;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= LSU_IDLE;
      r_cnt      <= '0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_rdata    <= '0;
      r_buserr   <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (i_mem_op) begin
            r_state    <= LSU_BUSY;
            r_dm_req   <= 1'b1;
            r_dm_we    <= i_we;
            r_dm_addr  <= i_addr;
            r_dm_wdata <= i_wdata;
            r_cnt      <= '0;
          end
        end
        LSU_BUSY: begin
          if (i_dm_ack) begin
            if (!r_dm_we) r_rdata <= i_dm_rdata;
            r_dm_req <= 1'b0;
            r_state  <= LSU_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // No ack within TIMEOUT BUSY cycles: abandon and flag the fault
            r_dm_req <= 1'b0;
            r_buserr <= 1'b1;
            r_state  <= LSU_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LSU_DONE: begin
          r_buserr <= 1'b0;
          r_state  <= LSU_IDLE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall = 1'b0;
    if (r_state == LSU_BUSY) w_stall = 1'b1;
    else if (r_state == LSU_IDLE && i_mem_op) w_stall = 1'b1;
  end

  assign o_dm_req    = r_dm_req;
  assign o_dm_we     = r_dm_we;
  assign o_dm_addr   = r_dm_addr;
  assign o_dm_wdata  = r_dm_wdata;
  assign o_stall_req = w_stall;
  assign o_rdata     = r_rdata;
  assign o_buserr    = r_buserr;

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS MEM stage: branch resolution, misalign/overflow squash, MEM/WB
// passthrough, and data-memory access through dmem_bus_fsm.
module mem_stage_lsu
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_MEM_ctrl_MemRead,
  input  logic              i_MEM_ctrl_MemWrite,
  input  logic              i_MEM_ctrl_Branch,
  input  logic              i_MEM_data_Zero,
  input  logic              i_MEM_data_Overflow,
  input  logic [DATA_W-1:0] i_MEM_data_ALUOut,
  input  logic [DATA_W-1:0] i_MEM_data_RTData,
  input  logic [DATA_W-1:0] i_MEM_data_PCBranch,
  input  logic              i_WB_ctrl_Mem2Reg,
  input  logic              i_WB_ctrl_RegWrite,
  input  logic [4:0]        i_WB_data_RegAddrW,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [DATA_W-1:0] o_dm_addr,
  output logic [DATA_W-1:0] o_dm_wdata,
  input  logic              i_dm_ack,
  input  logic [DATA_W-1:0] i_dm_rdata,
  output logic              o_stall_req,
  output logic              o_pc_src,
  output logic [DATA_W-1:0] o_pc_branch,
  output logic [DATA_W-1:0] o_WB_data_MemData,
  output logic [DATA_W-1:0] o_WB_data_ALUOut,
  output logic              o_WB_ctrl_Mem2Reg,
  output logic              o_WB_ctrl_RegWrite,
  output logic [4:0]        o_WB_data_RegAddrW,
  output logic              o_exc_misalign,
  output logic              o_exc_buserr
);

  logic              w_access;
  logic              w_misalign;
  logic              w_mem_op;
  logic              w_buserr;
  logic [DATA_W-1:0] w_rdata;

  assign w_access   = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;
  assign w_misalign = w_access & is_misaligned(i_MEM_data_ALUOut[1:0]);
  // Faulting ops retire without touching the bus
  assign w_mem_op   = w_access & ~i_MEM_data_Overflow & ~w_misalign;

  dmem_bus_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_bus (
    .clk         (clk),
    .nrst        (nrst),
    .i_mem_op    (w_mem_op),
    .i_we        (i_MEM_ctrl_MemWrite),
    .i_addr      (i_MEM_data_ALUOut),
    .i_wdata     (i_MEM_data_RTData),
    .i_dm_ack    (i_dm_ack),
    .i_dm_rdata  (i_dm_rdata),
    .o_dm_req    (o_dm_req),
    .o_dm_we     (o_dm_we),
    .o_dm_addr   (o_dm_addr),
    .o_dm_wdata  (o_dm_wdata),
    .o_stall_req (o_stall_req),
    .o_rdata     (w_rdata),
    .o_buserr    (w_buserr)
  );

  assign o_pc_src           = i_MEM_ctrl_Branch & i_MEM_data_Zero;
  assign o_pc_branch        = i_MEM_data_PCBranch;
  assign o_WB_data_MemData  = w_rdata;
  assign o_WB_data_ALUOut   = i_MEM_data_ALUOut;
  assign o_WB_ctrl_Mem2Reg  = i_WB_ctrl_Mem2Reg;
  assign o_WB_ctrl_RegWrite = i_WB_ctrl_RegWrite & ~i_MEM_data_Overflow
                              & ~w_misalign & ~w_buserr;
  assign o_WB_data_RegAddrW = i_WB_data_RegAddrW;
  assign o_exc_misalign     = w_misalign;
  assign o_exc_buserr       = w_buserr;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized transaction-level bench for mem_stage_lsu with a cycle-cost
// reference model of the memory handshake.
module tb_mem_stage_lsu;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 5;

  logic              clk = 1'b0;
  logic              nrst;
  logic              i_MEM_ctrl_MemRead, i_MEM_ctrl_MemWrite, i_MEM_ctrl_Branch;
  logic              i_MEM_data_Zero, i_MEM_data_Overflow;
  logic [DATA_W-1:0] i_MEM_data_ALUOut, i_MEM_data_RTData, i_MEM_data_PCBranch;
  logic              i_WB_ctrl_Mem2Reg, i_WB_ctrl_RegWrite;
  logic [4:0]        i_WB_data_RegAddrW;
  logic              o_dm_req, o_dm_we;
  logic [DATA_W-1:0] o_dm_addr, o_dm_wdata;
  logic              i_dm_ack;
  logic [DATA_W-1:0] i_dm_rdata;
  logic              o_stall_req, o_pc_src;
  logic [DATA_W-1:0] o_pc_branch, o_WB_data_MemData, o_WB_data_ALUOut;
  logic              o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite;
  logic [4:0]        o_WB_data_RegAddrW;
  logic              o_exc_misalign, o_exc_buserr;

  int unsigned       n_checks = 0;
  int unsigned       n_errors = 0;
  logic [DATA_W-1:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mem_stage_lsu #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .i_MEM_ctrl_MemRead  (i_MEM_ctrl_MemRead),
    .i_MEM_ctrl_MemWrite (i_MEM_ctrl_MemWrite),
    .i_MEM_ctrl_Branch   (i_MEM_ctrl_Branch),
    .i_MEM_data_Zero     (i_MEM_data_Zero),
    .i_MEM_data_Overflow (i_MEM_data_Overflow),
    .i_MEM_data_ALUOut   (i_MEM_data_ALUOut),
    .i_MEM_data_RTData   (i_MEM_data_RTData),
    .i_MEM_data_PCBranch (i_MEM_data_PCBranch),
    .i_WB_ctrl_Mem2Reg   (i_WB_ctrl_Mem2Reg),
    .i_WB_ctrl_RegWrite  (i_WB_ctrl_RegWrite),
    .i_WB_data_RegAddrW  (i_WB_data_RegAddrW),
    .o_dm_req            (o_dm_req),
    .o_dm_we             (o_dm_we),
    .o_dm_addr           (o_dm_addr),
    .o_dm_wdata          (o_dm_wdata),
    .i_dm_ack            (i_dm_ack),
    .i_dm_rdata          (i_dm_rdata),
    .o_stall_req         (o_stall_req),
    .o_pc_src            (o_pc_src),
    .o_pc_branch         (o_pc_branch),
    .o_WB_data_MemData   (o_WB_data_MemData),
    .o_WB_data_ALUOut    (o_WB_data_ALUOut),
    .o_WB_ctrl_Mem2Reg   (o_WB_ctrl_Mem2Reg),
    .o_WB_ctrl_RegWrite  (o_WB_ctrl_RegWrite),
    .o_WB_data_RegAddrW  (o_WB_data_RegAddrW),
    .o_exc_misalign      (o_exc_misalign),
    .o_exc_buserr        (o_exc_buserr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_nop();
    i_MEM_ctrl_MemRead  = 1'b0;
    i_MEM_ctrl_MemWrite = 1'b0;
    i_MEM_ctrl_Branch   = 1'b0;
    i_MEM_data_Zero     = 1'b0;
    i_MEM_data_Overflow = 1'b0;
    i_MEM_data_ALUOut   = '0;
    i_MEM_data_RTData   = '0;
    i_MEM_data_PCBranch = '0;
    i_WB_ctrl_Mem2Reg   = 1'b0;
    i_WB_ctrl_RegWrite  = 1'b0;
    i_WB_data_RegAddrW  = '0;
    i_dm_ack            = 1'b0;
    i_dm_rdata          = '0;
  endtask

  // One EX/MEM instruction. ack_dly = BUSY cycles before ack; >= TIMEOUT means never.
  task automatic run_op(input logic rd, input logic wr, input logic br, input logic zero,
                        input logic ovf, input logic [31:0] alu, input logic [31:0] rt,
                        input logic [31:0] pcb, input logic m2r, input logic rw,
                        input logic [4:0] ra, input int unsigned ack_dly,
                        input logic [31:0] rdat);
    logic        exp_mis, exp_mem, tmo;
    int unsigned busy, stalls;
    @(negedge clk);
    i_MEM_ctrl_MemRead  = rd;  i_MEM_ctrl_MemWrite = wr;  i_MEM_ctrl_Branch = br;
    i_MEM_data_Zero     = zero; i_MEM_data_Overflow = ovf;
    i_MEM_data_ALUOut   = alu; i_MEM_data_RTData = rt; i_MEM_data_PCBranch = pcb;
    i_WB_ctrl_Mem2Reg   = m2r; i_WB_ctrl_RegWrite = rw; i_WB_data_RegAddrW = ra;
    exp_mis = (rd | wr) && (alu % 4 != 0);
    exp_mem = (rd | wr) && !ovf && !exp_mis;
    // stray acks while idle must be ignored
    i_dm_ack   = exp_mem ? 1'b0 : 1'($urandom_range(0, 1));
    i_dm_rdata = $urandom;
    #1;
    chk("pc_src", o_pc_src, br & zero);
    chk("pc_branch", o_pc_branch, pcb);
    chk("misalign", o_exc_misalign, exp_mis);
    chk("stall_idle", o_stall_req, exp_mem);
    chk("req_idle", o_dm_req, 0);
    chk("buserr_idle", o_exc_buserr, 0);
    chk("memdata_idle", o_WB_data_MemData, exp_rdata);
    chk("wb_aluout", o_WB_data_ALUOut, alu);
    chk("wb_m2r_ra", {o_WB_ctrl_Mem2Reg, o_WB_data_RegAddrW}, {m2r, ra});
    if (!exp_mem) begin
      chk("regwrite_nomem", o_WB_ctrl_RegWrite, rw && !ovf && !exp_mis);
      return;
    end
    tmo    = (ack_dly >= TIMEOUT);
    busy   = tmo ? TIMEOUT : ack_dly + 1;
    stalls = o_stall_req ? 1 : 0;
    for (int unsigned c = 0; c < busy; c++) begin
      @(negedge clk);
      i_dm_ack   = (c == ack_dly);
      i_dm_rdata = (c == ack_dly) ? rdat : $urandom;
      #1;
      chk("req_busy", o_dm_req, 1);
      chk("we_busy", o_dm_we, wr);
      chk("addr_busy", o_dm_addr, alu);
      chk("wdata_busy", o_dm_wdata, rt);
      if (o_stall_req) stalls++;
    end
    @(negedge clk);
    i_dm_ack = 1'b0;
    if (!tmo && rd) exp_rdata = rdat;
    #1;
    if (o_stall_req) stalls++;
    chk("stall_cycles", stalls, busy + 1);
    chk("req_done", o_dm_req, 0);
    chk("buserr_done", o_exc_buserr, tmo);
    chk("regwrite_done", o_WB_ctrl_RegWrite, rw && !tmo);
    chk("memdata_done", o_WB_data_MemData, exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_nop();
    nrst = 1'b0;
    #1;
    chk("rst_req", o_dm_req, 0);
    chk("rst_we", o_dm_we, 0);
    chk("rst_addr", o_dm_addr, 0);
    chk("rst_wdata", o_dm_wdata, 0);
    chk("rst_memdata", o_WB_data_MemData, 0);
    chk("rst_buserr", o_exc_buserr, 0);
    chk("rst_stall", o_stall_req, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // load, ack on first BUSY cycle
    run_op(1, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 1, 1, 5'd3, 0, 32'hDEADBEEF);
    // store, three wait cycles
    run_op(0, 1, 0, 0, 0, 32'h204, 32'h12345678, 32'h0, 0, 0, 5'd0, 3, 32'h0);
    // misaligned load
    run_op(1, 0, 0, 0, 0, 32'h102, 32'h0, 32'h0, 1, 1, 5'd4, 0, 32'h0);
    // overflowing store squashed
    run_op(0, 1, 0, 0, 1, 32'h300, 32'h5, 32'h0, 0, 0, 5'd0, 0, 32'h0);
    // load timeout
    run_op(1, 0, 0, 0, 0, 32'h400, 32'h0, 32'h0, 1, 1, 5'd7, 100, 32'h0);
    // load acked on the last legal BUSY cycle
    run_op(1, 0, 0, 0, 0, 32'h404, 32'h0, 32'h0, 1, 1, 5'd7, TIMEOUT - 1, 32'hCAFEF00D);
    // branches
    run_op(0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h40, 0, 0, 5'd0, 0, 32'h0);
    run_op(0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h40, 0, 0, 5'd0, 0, 32'h0);

    // reset during BUSY, late ack ignored
    @(negedge clk);
    i_MEM_ctrl_MemRead = 1'b1; i_MEM_data_ALUOut = 32'h500; i_WB_ctrl_RegWrite = 1'b1;
    i_dm_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rstbusy_req_before", o_dm_req, 1);
    nrst = 1'b0;
    #1;
    chk("rstbusy_req", o_dm_req, 0);
    chk("rstbusy_addr", o_dm_addr, 0);
    chk("rstbusy_memdata", o_WB_data_MemData, 0);
    drive_nop();
    exp_rdata = '0;
    @(negedge clk);
    nrst = 1'b1;
    i_dm_ack = 1'b1; i_dm_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    i_dm_ack = 1'b0;
    #1;
    chk("rstbusy_late_ack", o_WB_data_MemData, 0);
    chk("rstbusy_req_after", o_dm_req, 0);
    chk("rstbusy_stall", o_stall_req, 0);

    for (int i = 0; i < 250; i++) begin
      int unsigned kind, dly;
      logic [31:0] alu;
      logic        ovf;
      kind = $urandom_range(0, 3);
      alu  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      ovf  = ($urandom_range(0, 7) == 0);
      dly  = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : $urandom_range(0, 5);
      case (kind)
        0: run_op(1, 0, 0, 0, ovf, alu, $urandom, $urandom, 1, 1,
                  5'($urandom), dly, $urandom);
        1: run_op(0, 1, 0, 0, ovf, alu, $urandom, $urandom, 0, 0,
                  5'($urandom), dly, $urandom);
        2: run_op(0, 0, 1, 1'($urandom), 0, alu, $urandom, $urandom, 0, 0,
                  5'($urandom), 0, 32'h0);
        default: run_op(0, 0, 0, 0, ovf, alu, $urandom, $urandom, 0, 1'($urandom),
                        5'($urandom), 0, 32'h0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
